// File: rtl/calendar_stopwatch.sv
// Prescaled second/minute/hour/day/month/year stopwatch with pause, preload, lap capture and
// year-overflow handling. Define REAL_CALENDAR_EN for true month lengths with leap Februaries.
module calendar_stopwatch #(
    parameter int CLK_PER_TICK   = 1000000,
    parameter int YEAR_W         = 7,
    parameter int DAYS_PER_MONTH = 30,
    parameter int YEAR_WRAP      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clear,
    input  logic                 load,
    input  logic [YEAR_W+25:0]   load_time,
    input  logic                 lap,
    output logic [5:0]           second,
    output logic [5:0]           minute,
    output logic [4:0]           hour,
    output logic [4:0]           day,
    output logic [3:0]           month,
    output logic [YEAR_W-1:0]    year,
    output logic                 running,
    output logic [YEAR_W+25:0]   lap_time,
    output logic                 lap_valid,
    output logic                 load_err,
    output logic                 overflow
);

    localparam int PW = $clog2(CLK_PER_TICK);

    typedef struct packed {
        logic [YEAR_W-1:0] year;
        logic [3:0]        month;
        logic [4:0]        day;
        logic [4:0]        hour;
        logic [5:0]        minute;
        logic [5:0]        second;
    } tm_t;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_t;

    localparam tm_t T0 = tm_t'({{YEAR_W{1'b0}}, 4'd1, 5'd1, 17'd0});

    state_t        state;
    tm_t           t, nt, ld;
    logic [PW-1:0] presc;
    logic [4:0]    cur_len, ld_len;
    logic          tick, ld_ok, at_max;
    logic          c_sec, c_min, c_hr, c_day, c_mon;

    assign ld = tm_t'(load_time);

`ifdef REAL_CALENDAR_EN
    function automatic logic [4:0] mlen(input logic [3:0] m, input logic [1:0] yl);
        case (m)
            4'd2:                      return (yl == 2'd0) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    assign cur_len = mlen(t.month, t.year[1:0]);
    assign ld_len  = mlen(ld.month, ld.year[1:0]);
`else
    assign cur_len = 5'(DAYS_PER_MONTH);
    assign ld_len  = 5'(DAYS_PER_MONTH);
`endif

    assign ld_ok = (ld.month >= 4'd1) && (ld.month <= 4'd12) &&
                   (ld.day >= 5'd1) && (ld.day <= ld_len) &&
                   (ld.hour < 5'd24) && (ld.minute < 6'd60) && (ld.second < 6'd60);

    // A stop on the same edge freezes the time base, so a resume keeps the exact phase.
    assign tick = (state == RUN) && !stop && (presc == PW'(CLK_PER_TICK - 1));

    assign c_sec  = (t.second == 6'd59);
    assign c_min  = c_sec && (t.minute == 6'd59);
    assign c_hr   = c_min && (t.hour == 5'd23);
    assign c_day  = c_hr && (t.day == cur_len);
    assign c_mon  = c_day && (t.month == 4'd12);
    assign at_max = c_mon && (t.year == {YEAR_W{1'b1}});

    always_comb begin
        nt        = t;
        nt.second = c_sec ? 6'd0 : t.second + 6'd1;
        if (c_sec) nt.minute = c_min ? 6'd0 : t.minute + 6'd1;
        if (c_min) nt.hour   = c_hr ? 5'd0 : t.hour + 5'd1;
        if (c_hr)  nt.day    = c_day ? 5'd1 : t.day + 5'd1;
        if (c_day) nt.month  = c_mon ? 4'd1 : t.month + 4'd1;
        if (c_mon) nt.year   = t.year + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            t         <= T0;
            state     <= IDLE;
            presc     <= '0;
            running   <= 1'b0;
            lap_time  <= '0;
            lap_valid <= 1'b0;
            load_err  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            load_err  <= 1'b0;
            lap_valid <= lap;
            if (lap) lap_time <= t;

            if (clear) begin
                t        <= T0;
                state    <= IDLE;
                presc    <= '0;
                running  <= 1'b0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    IDLE, PAUSE: begin
                        if (stop) begin
                            // stop dominates start; nothing moves
                        end else if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                            if (state == IDLE) presc <= '0;
                        end else if (load) begin
                            if (ld_ok) t <= ld;
                            else       load_err <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else begin
                            presc <= tick ? '0 : presc + PW'(1);
                            if (tick) begin
                                if (at_max) overflow <= 1'b1;
                                if (at_max && YEAR_WRAP == 0) begin
                                    state   <= HALT;
                                    running <= 1'b0;
                                end else begin
                                    t <= nt;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign second = t.second;
    assign minute = t.minute;
    assign hour   = t.hour;
    assign day    = t.day;
    assign month  = t.month;
    assign year   = t.year;

endmodule
